cic_decimator_ctrl: RTL and testbench
=====================================

// Module: cic_decimator_ctrl
// PURPOSE
//  Sequencer for the CIC decimator datapath: gates its input-sample enable, issues the reduced-rate substage strobe,
//  flushes integrators/combs on start-up or runtime rate change, and suppresses outputs until M*D reduced-rate samples
//  have settled. Sits between the ADC sample strobe and the CIC instance; host changes rate via a req/ack handshake.
// PARAMETERS
//  R_WIDTH      8  width of decimation rate; legal rate 1..2**R_WIDTH-1
//  DEFAULT_R    2  rate loaded at reset
//  M            2  CIC order (must match datapath)
//  D            2  CIC differential delay (must match datapath)
//  FLUSH_CYCLES 4  clk cycles cic_rst_n held low per flush, >=1
// PORTS
//  clk             in   1        system clock
//  rst_n           in   1        synchronous reset, active low
//  enabled         in   1        run request; 0 forces IDLE
//  sample_strobe   in   1        one-cycle pulse per input sample x
//  rate_req        in   1        rate change request (level, held until rate_ack)
//  rate_in         in   R_WIDTH  requested rate
//  rate_ack        out  1        one-cycle accept pulse
//  rate_err        out  1        one-cycle reject pulse (rate_in==0)
//  rate_cur        out  R_WIDTH  active rate
//  cic_rst_n       out  1        datapath reset, active low
//  cic_enabled     out  1        datapath sample enable (=sample_strobe in SETTLE/RUN)
//  substage_strobe out  1        one-cycle reduced-rate tick to comb stages
//  y_valid         out  1        datapath output y valid (RUN only)
//  state           out  2        IDLE=00 FLUSH=01 SETTLE=10 RUN=11
// BEHAVIOUR
//  - Reset (rst_n=0 at posedge): state=IDLE, rate_cur=DEFAULT_R, cic_rst_n=0, all other outputs 0, counters 0.
//  - All outputs registered except cic_enabled (combinational: sample_strobe & state in {SETTLE,RUN}).
//  - IDLE: cic_rst_n=0; enabled=1 -> FLUSH.
//  - FLUSH: cic_rst_n=0 for exactly FLUSH_CYCLES cycles, then -> SETTLE; dec_cnt, settle_cnt cleared.
//  - SETTLE/RUN: cic_rst_n=1. dec_cnt (R_WIDTH) increments per sample_strobe; strobe when dec_cnt==rate_cur-1
//    wraps it to 0 and asserts substage_strobe on the next cycle for one cycle. rate_cur=1 -> strobe per sample.
//  - SETTLE: settle_cnt ($clog2(M*D+1) bits) counts substage_strobe; on M*D-th -> RUN; y_valid stays 0.
//  - RUN: y_valid = substage_strobe (same cycle, one pulse per rate_cur samples).
//  - Handshake: rate_req sampled each cycle while rate_ack=0. rate_in!=0: rate_cur<=rate_in, rate_ack pulses next
//    cycle; if enabled, state -> FLUSH (FLUSH counter restarts if already in FLUSH). rate_in==0: rate_err pulses,
//    rate_cur and state unchanged. Requester drops rate_req after ack/err; a held req re-samples the cycle after.
//  - enabled=0 in any state -> IDLE next cycle, counters cleared, y_valid/substage_strobe 0 from that cycle.
//  - rate_req with enabled=0: accepted, rate_cur updated, stays IDLE; next enable uses new rate.
//  - Same-cycle enabled fall + rate_req: rate accepted, state -> IDLE (enable wins).
//  - sample_strobe in IDLE/FLUSH ignored. Pending substage_strobe is cancelled by a transition to FLUSH/IDLE.
//  - rst_n mid-operation: reset values next edge regardless of state/handshake.
// CONFIGURATION
//  CIC_CTRL_SAMPLE_COUNT_EN defined: extra port out_count out 16 = count of y_valid pulses since last entry to
//    FLUSH, saturating at 16'hFFFF, cleared by reset/FLUSH/IDLE. Undefined: port and counter absent; other
//    behaviour identical.
// TESTING
//  1 reset, enabled=1, sample_strobe every clk, R=2 -> cic_rst_n low 4 clks, 4 strobes in SETTLE, then y_valid every 2 clks.
//  2 in RUN, rate_req rate_in=5 -> rate_ack 1 clk, cic_rst_n low 4 clks, rate_cur=5, y_valid every 5 samples after settle.
//  3 rate_req rate_in=0 in RUN -> rate_err 1 clk, rate_cur=2, state stays 11, y_valid cadence unbroken.
//  4 sample_strobe every 3rd clk, R=4 -> substage_strobe every 12 clks; enabled=0 mid-RUN -> state 00 next clk, y_valid 0.
//  5 rst_n low 1 clk during SETTLE -> state 00, rate_cur=DEFAULT_R, all outputs reset values.
//  6 with CIC_CTRL_SAMPLE_COUNT_EN, R=1, 70000 samples in RUN -> out_count saturates 16'hFFFF; rate change clears to 0.

Source files
------------

// File: rtl/cic_decimator_ctrl.sv
// Sequencer for a CIC decimator: flushes the datapath, counts out the settling period and paces the
// reduced-rate strobes. Optional macro CIC_CTRL_SAMPLE_COUNT_EN adds an output-sample counter port.
module cic_decimator_ctrl #(
   parameter int unsigned R_WIDTH      = 8,
   parameter int unsigned DEFAULT_R    = 2,
   parameter int unsigned M            = 2,
   parameter int unsigned D            = 2,
   parameter int unsigned FLUSH_CYCLES = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               enabled,
   input  logic               sample_strobe,
   input  logic               rate_req,
   input  logic [R_WIDTH-1:0] rate_in,
   output logic               rate_ack,
   output logic               rate_err,
   output logic [R_WIDTH-1:0] rate_cur,
   output logic               cic_rst_n,
   output logic               cic_enabled,
   output logic               substage_strobe,
   output logic               y_valid,
   output logic [1:0]         state
`ifdef CIC_CTRL_SAMPLE_COUNT_EN
   ,
   output logic [15:0]        out_count
`endif
);

   localparam int unsigned SETTLE_N = M * D;
   localparam int unsigned SETTLE_W = $clog2(SETTLE_N + 1);
   localparam int unsigned FLUSH_W  = $clog2(FLUSH_CYCLES + 1);
   localparam int unsigned CNT_W    = 16;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'b00,
      ST_FLUSH  = 2'b01,
      ST_SETTLE = 2'b10,
      ST_RUN    = 2'b11
   } state_e;

   state_e               state_q, state_d;
   logic [R_WIDTH-1:0]   rate_cur_q, rate_cur_d;
   logic [R_WIDTH-1:0]   dec_cnt_q, dec_cnt_d;
   logic [SETTLE_W-1:0]  settle_cnt_q, settle_cnt_d;
   logic [FLUSH_W-1:0]   flush_cnt_q, flush_cnt_d;
   logic                 rate_ack_q, rate_ack_d;
   logic                 rate_err_q, rate_err_d;
   logic                 cic_rst_n_q, cic_rst_n_d;
   logic                 substage_q, substage_d;
   logic                 y_valid_q, y_valid_d;
   logic                 active_q, active_d;
   logic                 take, accept, reject, fire;
   logic [SETTLE_W-1:0]  settle_inc;

   assign active_q = (state_q == ST_SETTLE) || (state_q == ST_RUN);

   // Next-state, counters and registered output values
   always_comb begin
      state_d      = state_q;
      rate_cur_d   = rate_cur_q;
      dec_cnt_d    = dec_cnt_q;
      settle_cnt_d = settle_cnt_q;
      flush_cnt_d  = flush_cnt_q;
      rate_ack_d   = 1'b0;
      rate_err_d   = 1'b0;
      substage_d   = 1'b0;
      y_valid_d    = 1'b0;
      cic_rst_n_d  = 1'b0;
      active_d     = 1'b0;
      settle_inc   = settle_cnt_q + SETTLE_W'(1);

      // A request is only looked at once the previous ack/err pulse is gone
      take   = rate_req & ~rate_ack_q & ~rate_err_q;
      accept = take & (rate_in != '0);
      reject = take & (rate_in == '0);
      fire   = active_q & sample_strobe & (dec_cnt_q == rate_cur_q - R_WIDTH'(1));

      if (active_q && sample_strobe) begin
         dec_cnt_d = fire ? '0 : dec_cnt_q + R_WIDTH'(1);
      end

      case (state_q)
         ST_IDLE: begin
            state_d     = ST_FLUSH;
            flush_cnt_d = '0;
         end
         ST_FLUSH: begin
            if (flush_cnt_q == FLUSH_W'(FLUSH_CYCLES - 1)) begin
               state_d     = ST_SETTLE;
               flush_cnt_d = '0;
            end else begin
               flush_cnt_d = flush_cnt_q + FLUSH_W'(1);
            end
         end
         ST_SETTLE: begin
            if (substage_q) begin
               settle_cnt_d = settle_inc;
               if (settle_inc == SETTLE_W'(SETTLE_N)) begin
                  state_d = ST_RUN;
               end
            end
         end
         default: begin
            state_d = ST_RUN;
         end
      endcase

      if (accept) begin
         rate_cur_d = rate_in;
      end
      rate_ack_d = accept;
      rate_err_d = reject;

      // Disable beats a rate change; a rate change while running restarts the flush
      if (!enabled) begin
         state_d = ST_IDLE;
      end else if (accept) begin
         state_d     = ST_FLUSH;
         flush_cnt_d = '0;
      end

      active_d = (state_d == ST_SETTLE) || (state_d == ST_RUN);
      if (!active_d) begin
         dec_cnt_d    = '0;
         settle_cnt_d = '0;
      end
      if (state_d == ST_IDLE) begin
         flush_cnt_d = '0;
      end

      cic_rst_n_d = active_d;
      substage_d  = fire & active_d;
      y_valid_d   = fire & (state_d == ST_RUN);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         rate_cur_q   <= R_WIDTH'(DEFAULT_R);
         dec_cnt_q    <= '0;
         settle_cnt_q <= '0;
         flush_cnt_q  <= '0;
         rate_ack_q   <= 1'b0;
         rate_err_q   <= 1'b0;
         cic_rst_n_q  <= 1'b0;
         substage_q   <= 1'b0;
         y_valid_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         rate_cur_q   <= rate_cur_d;
         dec_cnt_q    <= dec_cnt_d;
         settle_cnt_q <= settle_cnt_d;
         flush_cnt_q  <= flush_cnt_d;
         rate_ack_q   <= rate_ack_d;
         rate_err_q   <= rate_err_d;
         cic_rst_n_q  <= cic_rst_n_d;
         substage_q   <= substage_d;
         y_valid_q    <= y_valid_d;
      end
   end

`ifdef CIC_CTRL_SAMPLE_COUNT_EN
   logic [CNT_W-1:0] out_count_q, out_count_d;

   // Saturating count of output samples since the last flush
   always_comb begin
      out_count_d = out_count_q;
      if (!active_d) begin
         out_count_d = '0;
      end else if (y_valid_d && (out_count_q != {CNT_W{1'b1}})) begin
         out_count_d = out_count_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_count_q <= '0;
      end else begin
         out_count_q <= out_count_d;
      end
   end

   assign out_count = out_count_q;
`endif

   assign state           = state_q;
   assign rate_cur        = rate_cur_q;
   assign rate_ack        = rate_ack_q;
   assign rate_err        = rate_err_q;
   assign cic_rst_n       = cic_rst_n_q;
   assign substage_strobe = substage_q;
   assign y_valid         = y_valid_q;
   assign cic_enabled     = sample_strobe & active_q;

endmodule

// File: tb/tb_cic_decimator_ctrl.sv
// Bench for cic_decimator_ctrl: directed scenarios plus random traffic, every cycle compared
// against a behavioural model of flush length, sample grouping and settle counting.
module tb_cic_decimator_ctrl;

   localparam int FC   = 4;
   localparam int MD   = 4;
   localparam int DEFR = 2;

   logic       clk;
   logic       rst_n;
   logic       enabled;
   logic       sample_strobe;
   logic       rate_req;
   logic [7:0] rate_in;
   logic       rate_ack;
   logic       rate_err;
   logic [7:0] rate_cur;
   logic       cic_rst_n;
   logic       cic_enabled;
   logic       substage_strobe;
   logic       y_valid;
   logic [1:0] state;
`ifdef CIC_CTRL_SAMPLE_COUNT_EN
   logic [15:0] out_count;
`endif

   cic_decimator_ctrl #(
      .R_WIDTH(8), .DEFAULT_R(DEFR), .M(2), .D(2), .FLUSH_CYCLES(FC)
   ) dut (
      .clk(clk), .rst_n(rst_n), .enabled(enabled), .sample_strobe(sample_strobe),
      .rate_req(rate_req), .rate_in(rate_in), .rate_ack(rate_ack), .rate_err(rate_err),
      .rate_cur(rate_cur), .cic_rst_n(cic_rst_n), .cic_enabled(cic_enabled),
      .substage_strobe(substage_strobe), .y_valid(y_valid), .state(state)
`ifdef CIC_CTRL_SAMPLE_COUNT_EN
      , .out_count(out_count)
`endif
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Behavioural model: mode 0..3 = idle/flush/settle/run
   int m_mode = 0, m_rate = DEFR, m_flush_left = 0, m_grp = 0, m_settled = 0, m_cnt = 0;
   bit m_ack = 0, m_err = 0, m_sub = 0, m_yv = 0;

   task automatic model_step();
      int  old_mode;
      bit  old_sub, take, fire;
      if (!rst_n) begin
         m_mode = 0; m_rate = DEFR; m_flush_left = 0; m_grp = 0; m_settled = 0;
         m_ack = 0; m_err = 0; m_sub = 0; m_yv = 0; m_cnt = 0;
         return;
      end
      old_mode = m_mode;
      old_sub  = m_sub;
      take     = rate_req && !m_ack && !m_err;
      fire     = 0;
      if (old_mode >= 2 && sample_strobe) begin
         m_grp++;
         if (m_grp == m_rate) begin
            fire  = 1;
            m_grp = 0;
         end
      end
      m_ack = take && (rate_in != 0);
      m_err = take && (rate_in == 0);
      if (m_ack) m_rate = int'(rate_in);
      if (!enabled) m_mode = 0;
      else if (m_ack || old_mode == 0) begin
         m_mode = 1;
         m_flush_left = FC;
      end else if (old_mode == 1) begin
         m_flush_left--;
         if (m_flush_left == 0) m_mode = 2;
      end else if (old_mode == 2 && old_sub) begin
         m_settled++;
         if (m_settled == MD) m_mode = 3;
      end
      if (m_mode <= 1) begin
         m_grp = 0;
         m_settled = 0;
      end
      m_sub = fire && (m_mode >= 2);
      m_yv  = fire && (m_mode == 3);
      if (m_mode <= 1) m_cnt = 0;
      else if (m_yv && m_cnt < 65535) m_cnt++;
   endtask

   always @(posedge clk) model_step();

   task automatic compare_all();
      check_eq("state", 32'(state), 32'(m_mode));
      check_eq("rate_cur", 32'(rate_cur), 32'(m_rate));
      check_eq("rate_ack", 32'(rate_ack), 32'(m_ack));
      check_eq("rate_err", 32'(rate_err), 32'(m_err));
      check_eq("cic_rst_n", 32'(cic_rst_n), 32'(m_mode >= 2));
      check_eq("cic_enabled", 32'(cic_enabled), 32'(sample_strobe && m_mode >= 2));
      check_eq("substage_strobe", 32'(substage_strobe), 32'(m_sub));
      check_eq("y_valid", 32'(y_valid), 32'(m_yv));
`ifdef CIC_CTRL_SAMPLE_COUNT_EN
      check_eq("out_count", 32'(out_count), 32'(m_cnt));
`endif
   endtask

   int cyc = 0;
   int strobe_period = 1;

   task automatic step_cycle();
      @(posedge clk);
      @(negedge clk);
      compare_all();
      cyc++;
      if (strobe_period > 0) sample_strobe = ((cyc % strobe_period) == 0);
   endtask

   task automatic wait_state(input logic [1:0] s, input int budget, input string tag);
      for (int k = 0; k < budget && state !== s; k++) step_cycle();
      check_eq(tag, 32'(state), 32'(s));
   endtask

   task automatic req_rate(input logic [7:0] r);
      rate_req = 1'b1;
      rate_in  = r;
      for (int k = 0; k < 6 && !(rate_ack || rate_err); k++) step_cycle();
      check_eq("handshake_done", 32'(rate_ack | rate_err), 32'd1);
      rate_req = 1'b0;
   endtask

   initial begin
      int lowcnt, t0, t1, dens;
      rst_n = 1'b0; enabled = 1'b0; sample_strobe = 1'b0; rate_req = 1'b0; rate_in = '0;
      strobe_period = 0;
      repeat (3) step_cycle();
      check_eq("reset_state", 32'(state), 32'd0);
      check_eq("reset_rate", 32'(rate_cur), 32'(DEFR));

      // 1: bring-up at R=2 with a sample every clock
      rst_n = 1'b1; enabled = 1'b1; strobe_period = 1;
      lowcnt = 0;
      for (int k = 0; k < 12; k++) begin
         step_cycle();
         if (state == 2'b01) lowcnt++;
      end
      check_eq("flush_len_startup", 32'(lowcnt), 32'(FC));
      wait_state(2'b11, 40, "reach_run_r2");
      repeat (10) step_cycle();

      // 3: zero rate rejected while running
      req_rate(8'd0);
      check_eq("err_keeps_run", 32'(state), 32'd3);
      check_eq("err_keeps_rate", 32'(rate_cur), 32'd2);
      repeat (8) step_cycle();

      // 2: runtime change to R=5 flushes for FC cycles
      req_rate(8'd5);
      lowcnt = 0;
      for (int k = 0; k < 10; k++) begin
         if (cic_rst_n == 1'b0) lowcnt++;
         step_cycle();
      end
      check_eq("flush_len_rate", 32'(lowcnt), 32'(FC));
      check_eq("rate_now_5", 32'(rate_cur), 32'd5);
      wait_state(2'b11, 60, "reach_run_r5");
      repeat (20) step_cycle();

      // 4: one sample per 3 clocks at R=4 -> substage every 12 clocks
      strobe_period = 3;
      req_rate(8'd4);
      wait_state(2'b11, 300, "reach_run_r4");
      t0 = -1; t1 = -1;
      for (int k = 0; k < 60 && t1 < 0; k++) begin
         step_cycle();
         if (substage_strobe) begin
            if (t0 < 0) t0 = cyc;
            else t1 = cyc;
         end
      end
      check_eq("substage_period", 32'(t1 - t0), 32'd12);
      enabled = 1'b0;
      step_cycle();
      check_eq("disable_idle", 32'(state), 32'd0);
      check_eq("disable_yvalid", 32'(y_valid), 32'd0);

      // 5: reset pulse during SETTLE
      enabled = 1'b1;
      wait_state(2'b10, 40, "reach_settle");
      rst_n = 1'b0;
      step_cycle();
      rst_n = 1'b1;
      check_eq("midreset_state", 32'(state), 32'd0);
      check_eq("midreset_rate", 32'(rate_cur), 32'(DEFR));
      check_eq("midreset_cicrst", 32'(cic_rst_n), 32'd0);

      // Random traffic
      strobe_period = 0;
      dens = 1;
      for (int i = 0; i < 15000; i++) begin
         rst_n = ($urandom_range(0, 999) >= 3);
         if ($urandom_range(0, 99) == 0) enabled = ~enabled;
         if ($urandom_range(0, 199) == 0) dens = $urandom_range(1, 4);
         sample_strobe = ($urandom_range(0, dens - 1) == 0);
         if (rate_req && (rate_ack || rate_err)) begin
            if ($urandom_range(0, 9) < 8) rate_req = 1'b0;
         end else if (!rate_req && $urandom_range(0, 99) == 0) begin
            rate_req = 1'b1;
            case ($urandom_range(0, 19))
               0, 1:    rate_in = 8'd0;
               2:       rate_in = 8'd255;
               default: rate_in = 8'($urandom_range(1, 6));
            endcase
         end
         step_cycle();
      end
      rate_req = 1'b0;
      rst_n = 1'b1;

`ifdef CIC_CTRL_SAMPLE_COUNT_EN
      // 6: saturate the output counter at R=1, then clear it with a rate change
      enabled = 1'b1;
      strobe_period = 1;
      req_rate(8'd1);
      wait_state(2'b11, 60, "reach_run_r1");
      for (int k = 0; k < 65600; k++) step_cycle();
      check_eq("count_saturated", 32'(out_count), 32'h0000FFFF);
      req_rate(8'd2);
      check_eq("count_cleared", 32'(out_count), 32'd0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
